// File: rtl/prs_checker.sv
// prs_checker
// Serial pseudo-random sequence checker. Self-synchronises to an incoming
// PRBS stream produced by a Fibonacci LFSR with the same TAPS, declares lock
// after LOCK_CNT consecutive predicted bits match, then counts bit errors.
// Too many errors within one WINDOW of valid bits drops lock and reseeds.
//
// Optional feature: define PRS_CHECKER_LOL_EN to add the sticky loss-of-lock
// output `lol`.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset
//   in_valid in   qualifies in_bit
//   in_bit   in   received serial bit
//   clear    in   synchronous clear of err_cnt/bit_cnt (and lol)
//   locked   out  high while in LOCKED
//   err      out  one-cycle pulse per mismatched bit while locked
//   err_cnt  out  saturating error count while locked
//   bit_cnt  out  saturating count of valid bits checked while locked
//   lol      out  sticky loss-of-lock (PRS_CHECKER_LOL_EN only)
//
// state  | meaning
// SEED   | shifting raw received bits into the LFSR state
// VERIFY | predicting bits; counting consecutive matches towards lock
// LOCKED | predicting bits; counting errors and monitoring the window
module prs_checker #(
  parameter int             N          = 16,
  parameter logic [N-1:0]   TAPS       = 16'hB400,
  parameter int             LOCK_CNT   = 32,
  parameter int             WINDOW     = 64,
  parameter int             ERR_THRESH = 8,
  parameter int             CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             clear,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
`ifdef PRS_CHECKER_LOL_EN
  output logic             lol,
`endif
  output logic [CNT_W-1:0] bit_cnt
);

  localparam int SW = $clog2(N + 1);
  localparam int VW = $clog2(LOCK_CNT + 1);
  localparam int PW = $clog2(WINDOW);
  localparam int EW = $clog2(ERR_THRESH + 1);

  localparam logic [1:0] SEED   = 2'd0;
  localparam logic [1:0] VERIFY = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  logic [1:0]    fsm;
  logic [N-1:0]  state;
  logic [SW-1:0] seed_cnt;
  logic [VW-1:0] vcnt;
  logic [PW-1:0] win_pos;
  logic [EW-1:0] win_err;

  logic          pred;
  logic [N-1:0]  seed_next;
  logic          bit_ev;
  logic          err_ev;
  logic [EW-1:0] win_err_next;

  assign pred         = ^(state & TAPS);
  assign seed_next    = {state[N-2:0], in_bit};
  assign bit_ev       = in_valid && (fsm == LOCKED);
  assign err_ev       = bit_ev && (in_bit != pred);
  assign win_err_next = win_err + EW'(1);

  // clear restarts the count from zero but still takes this cycle's event.
  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] cur,
                                            input logic clr,
                                            input logic ev);
    logic [CNT_W-1:0] base;
    base = clr ? '0 : cur;
    if (ev && (base != '1)) bump = base + CNT_W'(1);
    else                    bump = base;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm      <= SEED;
      state    <= '0;
      seed_cnt <= '0;
      vcnt     <= '0;
      win_pos  <= '0;
      win_err  <= '0;
      locked   <= 1'b0;
      err      <= 1'b0;
      err_cnt  <= '0;
      bit_cnt  <= '0;
`ifdef PRS_CHECKER_LOL_EN
      lol      <= 1'b0;
`endif
    end else begin
      err     <= err_ev;
      err_cnt <= bump(err_cnt, clear, err_ev);
      bit_cnt <= bump(bit_cnt, clear, bit_ev);
`ifdef PRS_CHECKER_LOL_EN
      if (clear) lol <= 1'b0;
`endif
      if (in_valid) begin
        case (fsm)
          SEED: begin
            state <= seed_next;
            if (seed_cnt == SW'(N - 1)) begin
              seed_cnt <= '0;
              // An all-zero state would predict zeros forever; keep seeding.
              if (seed_next != '0) begin
                fsm  <= VERIFY;
                vcnt <= '0;
              end
            end else begin
              seed_cnt <= seed_cnt + SW'(1);
            end
          end
          VERIFY: begin
            if (in_bit == pred) begin
              state <= {state[N-2:0], pred};
              if (vcnt == VW'(LOCK_CNT - 1)) begin
                fsm     <= LOCKED;
                locked  <= 1'b1;
                win_pos <= '0;
                win_err <= '0;
              end else begin
                vcnt <= vcnt + VW'(1);
              end
            end else begin
              fsm      <= SEED;
              seed_cnt <= '0;
            end
          end
          LOCKED: begin
            // Only predicted bits enter the state, so errors never propagate.
            state <= {state[N-2:0], pred};
            if (err_ev && (win_err_next == EW'(ERR_THRESH))) begin
              fsm      <= SEED;
              seed_cnt <= '0;
              locked   <= 1'b0;
              win_pos  <= '0;
              win_err  <= '0;
`ifdef PRS_CHECKER_LOL_EN
              lol      <= 1'b1;
`endif
            end else if (win_pos == PW'(WINDOW - 1)) begin
              win_pos <= '0;
              win_err <= '0;
            end else begin
              win_pos <= win_pos + PW'(1);
              if (err_ev) win_err <= win_err_next;
            end
          end
          default: begin
            fsm      <= SEED;
            seed_cnt <= '0;
            locked   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prs_checker.sv
// Directed testbench for prs_checker with a reference LFSR generator.
module tb_prs_checker;

  localparam logic [15:0] TAPS = 16'hB400;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_bit;
  logic        clear;
  logic        locked;
  logic        err;
  logic [31:0] err_cnt;
  logic [31:0] bit_cnt;
`ifdef PRS_CHECKER_LOL_EN
  logic        lol;
`endif

  int checks   = 0;
  int failures = 0;
  int err_seen = 0;
  int lock_seen = 0;
  logic [15:0] g;

  always #5 clk = ~clk;

  prs_checker dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
    .clear(clear), .locked(locked), .err(err), .err_cnt(err_cnt),
`ifdef PRS_CHECKER_LOL_EN
    .lol(lol),
`endif
    .bit_cnt(bit_cnt)
  );

  // One clock: present a bit (generator output, optionally flipped), step
  // the generator on valid cycles, sample outputs 1 time unit after the edge.
  task automatic drive(input logic v, input logic flip, input logic clr);
    logic gb;
    gb       = ^(g & TAPS);
    in_valid = v;
    clear    = clr;
    in_bit   = v ? (gb ^ flip) : 1'b1;
    @(posedge clk);
    if (v) g = {g[14:0], gb};
    #1;
    clear = 1'b0;
    if (err) err_seen++;
    if (locked) lock_seen++;
  endtask

  task automatic do_reset(input logic [15:0] seed);
    rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; clear = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    g = seed;
  endtask

  task automatic lock_wait(output int n);
    n = 0;
    while (!locked && n < 200) begin
      drive(1'b1, 1'b0, 1'b0);
      n++;
    end
  endtask

  task automatic test_reset;
    do_reset(16'hACE1);
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL reset_locked got=%b exp=0", locked); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (err_cnt !== 32'd0) begin failures++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
    checks++; if (bit_cnt !== 32'd0) begin failures++; $display("FAIL reset_bit_cnt got=%0d exp=0", bit_cnt); end
  endtask

  task automatic test_clean;
    int n;
    do_reset(16'hACE1);
    lock_wait(n);
    checks++; if (n !== 48) begin failures++; $display("FAIL clean_lock_bits got=%0d exp=48", n); end
    err_seen = 0;
    for (int i = 0; i < 1000; i++) drive(1'b1, 1'b0, 1'b0);
    checks++; if (err_seen !== 0) begin failures++; $display("FAIL clean_err_pulses got=%0d exp=0", err_seen); end
    checks++; if (err_cnt !== 32'd0) begin failures++; $display("FAIL clean_err_cnt got=%0d exp=0", err_cnt); end
    checks++; if (bit_cnt !== 32'd1000) begin failures++; $display("FAIL clean_bit_cnt got=%0d exp=1000", bit_cnt); end
  endtask

  task automatic test_single_error;
    err_seen = 0;
    drive(1'b1, 1'b1, 1'b0);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL single_err_pulse got=%b exp=1", err); end
    drive(1'b1, 1'b0, 1'b0);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL single_err_width got=%b exp=0", err); end
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, 1'b0);
    checks++; if (err_seen !== 1) begin failures++; $display("FAIL single_err_pulses got=%0d exp=1", err_seen); end
    checks++; if (err_cnt !== 32'd1) begin failures++; $display("FAIL single_err_cnt got=%0d exp=1", err_cnt); end
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL single_locked got=%b exp=1", locked); end
  endtask

  task automatic test_burst;
    int n;
    do_reset(16'h1234);
    lock_wait(n);
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b1, 1'b0);
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL burst_locked_after7 got=%b exp=1", locked); end
    drive(1'b1, 1'b1, 1'b0);
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL burst_locked_after8 got=%b exp=0", locked); end
    checks++; if (err_cnt !== 32'd8) begin failures++; $display("FAIL burst_err_cnt got=%0d exp=8", err_cnt); end
`ifdef PRS_CHECKER_LOL_EN
    checks++; if (lol !== 1'b1) begin failures++; $display("FAIL burst_lol got=%b exp=1", lol); end
`endif
    lock_wait(n);
    checks++; if (n !== 48) begin failures++; $display("FAIL burst_relock_bits got=%0d exp=48", n); end
    checks++; if (err_cnt !== 32'd8) begin failures++; $display("FAIL burst_err_cnt_relock got=%0d exp=8", err_cnt); end
  endtask

  task automatic test_window_spread;
    int n;
    do_reset(16'hBEEF);
    lock_wait(n);
    // errors at window positions 57..63 then 0..6 of the next window
    for (int i = 0; i < 57; i++) drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) drive(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 1'b0);
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL spread_locked got=%b exp=1", locked); end
    checks++; if (err_cnt !== 32'd14) begin failures++; $display("FAIL spread_err_cnt got=%0d exp=14", err_cnt); end
  endtask

  task automatic test_all_zero;
    do_reset(16'h0000);
    err_seen = 0; lock_seen = 0;
    for (int i = 0; i < 500; i++) drive(1'b1, 1'b0, 1'b0);
    checks++; if (lock_seen !== 0) begin failures++; $display("FAIL zero_locked_cycles got=%0d exp=0", lock_seen); end
    checks++; if (err_seen !== 0) begin failures++; $display("FAIL zero_err_pulses got=%0d exp=0", err_seen); end
  endtask

  task automatic test_gaps;
    int n;
    do_reset(16'h5A5A);
    n = 0;
    while (!locked && n < 200) begin
      drive(1'b1, 1'b0, 1'b0);
      n++;
      if (!locked) drive(1'b0, 1'b0, 1'b0);
    end
    checks++; if (n !== 48) begin failures++; $display("FAIL gaps_lock_bits got=%0d exp=48", n); end
  endtask

  task automatic test_clear_error;
    drive(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b0);
    checks++; if (err_cnt !== 32'd1) begin failures++; $display("FAIL clear_pre_err_cnt got=%0d exp=1", err_cnt); end
    drive(1'b1, 1'b1, 1'b1);
    checks++; if (err_cnt !== 32'd1) begin failures++; $display("FAIL clear_err_cnt got=%0d exp=1", err_cnt); end
    checks++; if (bit_cnt !== 32'd1) begin failures++; $display("FAIL clear_bit_cnt got=%0d exp=1", bit_cnt); end
    drive(1'b1, 1'b0, 1'b0);
    checks++; if (bit_cnt !== 32'd2) begin failures++; $display("FAIL clear_bit_cnt_next got=%0d exp=2", bit_cnt); end
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL clear_locked got=%b exp=1", locked); end
    drive(1'b0, 1'b0, 1'b1);
    checks++; if (bit_cnt !== 32'd0) begin failures++; $display("FAIL clear_idle_bit_cnt got=%0d exp=0", bit_cnt); end
  endtask

  task automatic test_rst_locked;
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b0);
    rst = 1'b0;
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL rst_locked got=%b exp=0", locked); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", err); end
    checks++; if (err_cnt !== 32'd0) begin failures++; $display("FAIL rst_err_cnt got=%0d exp=0", err_cnt); end
    checks++; if (bit_cnt !== 32'd0) begin failures++; $display("FAIL rst_bit_cnt got=%0d exp=0", bit_cnt); end
  endtask

  initial begin
    test_reset;
    test_clean;
    test_single_error;
    test_burst;
    test_window_spread;
    test_all_zero;
    test_gaps;
    test_clear_error;
    test_rst_locked;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prs_checker.md
# prs_checker

Serial pseudo-random sequence checker: receiver-side counterpart to the PRS generator. It self-synchronises to an incoming PRBS bit stream from the same Fibonacci LFSR polynomial, declares lock, then counts bit errors. It sits at the far end of a link or loopback path under test and feeds lock/error status to the bench or to a status register block.

## Interface
- N, 16, LFSR length in bits (N ≥ 3)
- TAPS, 16'hB400, feedback mask over state bits; predicted bit = XOR-reduce(state & TAPS)
- LOCK_CNT, 32, consecutive matching bits required to declare lock
- WINDOW, 64, error-monitoring window length in valid bits while locked
- ERR_THRESH, 8, errors within one window that force loss of lock
- CNT_W, 32, width of err_cnt and bit_cnt
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  in_bit is sampled only when high
- in_bit  in  1  received serial bit
- clear  in  1  synchronous clear of err_cnt, bit_cnt (and lol when compiled in)
- locked  out  1  high while in LOCKED
- err  out  1  one-cycle pulse per mismatched bit while LOCKED
- err_cnt  out  CNT_W  saturating count of errors while LOCKED
- bit_cnt  out  CNT_W  saturating count of valid bits checked while LOCKED

## Operation
- State register `state[N-1:0]`. Shift is `state <= {state[N-2:0], b}`; `pred = ^(state & TAPS)`.
- FSM states: SEED, VERIFY, LOCKED. Nothing advances while in_valid is low.
- SEED: shift in in_bit; seed_cnt counts valid bits. On the N-th bit, go to VERIFY with vcnt = 0. If the state after the N-th bit is all zeros, stay in SEED and restart seed_cnt at 0.
- VERIFY: compare in_bit with pred and shift in pred.
  - Match: vcnt++. The LOCK_CNT-th consecutive match moves the FSM to LOCKED.
  - Mismatch: go to SEED with seed_cnt = 0. The mismatching bit is discarded.
- LOCKED: compare in_bit with pred and shift in pred. Received bits never enter the state, so a single error produces exactly one err pulse.
  - bit_cnt++ on every valid bit.
  - On mismatch: err pulse, err_cnt++, win_err++.
  - win_pos counts valid bits 0..WINDOW-1. On the WINDOW-th bit, win_pos and win_err reset to 0.
  - If win_err reaches ERR_THRESH, go to SEED with seed_cnt = 0 and locked low. The threshold check takes priority over a window end in the same cycle.
- Counters saturate at 2^CNT_W−1 and do not wrap.
- clear: the counter takes 0 plus the current cycle's event. A clear coinciding with an error gives err_cnt = 1 and bit_cnt = 1. clear has no effect on FSM, state, or window counters.
- Reset mid-operation returns the FSM to SEED immediately, regardless of state or in_valid.

## Timing
- Reset values: locked = 0, err = 0, err_cnt = 0, bit_cnt = 0, lol = 0. FSM is in SEED with state, seed_cnt, vcnt, win_pos and win_err all 0.
- All outputs are registered.
- err is high in the cycle after the erroneous bit is sampled, for exactly one cycle.
- locked rises in the cycle after the LOCK_CNT-th verified bit is sampled. From reset with continuous valid input, locked rises N + LOCK_CNT cycles after the first valid bit is sampled.
- locked falls in the cycle after the bit that brings win_err to ERR_THRESH.
- Counters update in the same cycle as err.

## Configuration
- PRS_CHECKER_LOL_EN defined:
  - Adds output `lol  out  1`, a sticky loss-of-lock flag.
  - lol is set in the cycle locked falls because of ERR_THRESH.
  - lol is cleared only by rst or clear; if clear and a loss of lock coincide, set wins.
- PRS_CHECKER_LOL_EN undefined: the lol port and its logic are absent. All other behaviour is identical.

## Test plan
- Clean stream: matching 16-bit generator with TAPS 16'hB400 and a non-zero seed, in_valid held high. Required: locked rises at cycle 48 after the first valid bit; after 1000 further bits, err_cnt = 0 and bit_cnt = 1000.
- Single error: flip 1 bit while locked. Required: exactly one err pulse, err_cnt = 1, locked stays high.
- Burst: flip 8 bits within one 64-bit window. Required: locked falls after the 8th error, err_cnt = 8. The checker relocks within N + LOCK_CNT valid bits once errors stop (lol = 1 when PRS_CHECKER_LOL_EN is defined).
- Window spread: 7 errors in window k and 7 in window k+1. Required: locked stays high and err_cnt = 14.
- All-zero input: in_valid high for 500 cycles with in_bit = 0. Required: locked never asserts and err never pulses.
- in_valid gaps, clear and rst:
  - Toggle in_valid with 50 % duty: lock takes 48 valid bits.
  - Assert clear together with an error: err_cnt = 1.
  - Assert rst while locked: every output is 0 in the next cycle.
